led_show_sequencer: RTL
=======================

# led_show_sequencer

Autonomous show controller for `led_pattern_generator`. It stores a programmable playlist of up to 8 steps; each step holds a pattern, a speed and a duration. On start it walks the playlist at the base tick rate and drives the generator's `pat_sel`, `speed_sel`, `pause` and `ena` inputs. It sits between the top-level control inputs (buttons and config registers) and the generator.

## Interface
- `DEPTH`, 8: number of playlist entries; the address width is fixed at 3 bits.
- `clk`, input, 1: system clock; the same clock drives the generator.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `tick`, input, 1: single-cycle strobe at the base beat rate (8 Hz). Durations are counted in ticks.
- `cfg_we`, input, 1: playlist write strobe.
- `cfg_addr`, input, 3: entry index to write.
- `cfg_data`, input, 8: entry content `{speed[7], pat[6:4], dur[3:0]}`.
- `cfg_len`, input, 3: index of the last step. It is sampled only when `start` is accepted.
- `loop`, input, 1: when high, the playlist repeats after the last step. It is sampled at the end of each pass.
- `start`, input, 1: single-cycle request that starts or restarts playback at step 0.
- `stop`, input, 1: single-cycle request that aborts playback and returns to IDLE.
- `pause_req`, input, 1: level input; while high, playback holds.
- `pat_sel`, output, 3: to the generator.
- `speed_sel`, output, 1: to the generator.
- `pause`, output, 1: to the generator.
- `gen_ena`, output, 1: to the generator's `ena`.
- `step_idx`, output, 3: index of the current step.
- `busy`, output, 1: high in PLAY and HOLD.
- `done`, output, 1: single-cycle pulse when a non-looping pass completes.

## Operation
- **Playlist storage:** an 8x8 register array, written on any cycle with `cfg_we=1`, in any state.
  - A write to the active step does not alter the step in progress. The new value takes effect the next time that step is loaded.
  - Reset clears all entries to 0x00.
- **States:** IDLE, PLAY, HOLD.
- **IDLE:**
  - Outputs: `pat_sel=3'b111` (all off), `speed_sel=0`, `pause=0`, `busy=0`.
  - `start` → PLAY. The sequencer latches `cfg_len`, loads step 0 and clears the beat counter.
- **PLAY:**
  - Outputs present the current entry's pat and speed, with `pause=0`.
  - Each `tick` increments the beat counter.
  - When a tick arrives and the beat count equals `dur-1`, the step ends. A `dur` value of 0 means 16 ticks.
  - At the end of a step:
    - If `step_idx < len`: load `step_idx+1` and clear the counter.
    - If `step_idx == len` and `loop=1`: load step 0.
    - If `step_idx == len` and `loop=0`: go to IDLE and pulse `done`.
- **HOLD:**
  - Entered from PLAY while `pause_req=1`. It returns to PLAY on the first cycle with `pause_req=0`.
  - Outputs hold the current step with `pause=1`.
  - Ticks are ignored, and the beat counter and step are frozen.
- **Priority on the same cycle, highest first:**
  1. `stop` → IDLE, with no `done` pulse.
  2. `start` → PLAY at step 0, even from PLAY or HOLD.
  3. `pause_req`.
  4. Tick or step advance.
- Entering PLAY from `start` while `pause_req=1` goes to PLAY for one cycle, then to HOLD.
- `cfg_len` greater than `DEPTH-1` cannot occur because the port is 3 bits wide.

## Timing
- All outputs are registered.
- **Reset values:**
  - Outputs: `pat_sel=3'b111`, `speed_sel=0`, `pause=0`, `gen_ena=0`, `step_idx=0`, `busy=0`, `done=0`.
  - State: IDLE, with the beat counter at 0.
- `gen_ena` goes to 1 on the first clock edge after reset release and stays at 1.
- A `start` sampled at edge N produces step 0's outputs and `busy=1` after edge N+1.
- A step-ending `tick` at edge N produces the next step's `pat_sel`, `speed_sel` and `step_idx` after edge N+1. On the final step, the IDLE outputs and `done=1` appear after edge N+1, and `done` clears after edge N+2.
- `pause_req` rising at edge N gives `pause=1` after edge N+1. A tick on the same edge is ignored.
- `tick` and `start` arriving together: the tick is not counted toward step 0.
- Asserting reset mid-playback forces all reset values immediately, without waiting for a clock edge. The playlist is cleared.

## Configuration
- **`SEQ_MANUAL_OVERRIDE_EN` defined:** adds three inputs: `man_sel` (1 bit), `man_pat` (3 bits) and `man_speed` (1 bit).
  - While `man_sel=1`, `pat_sel`, `speed_sel` and `pause` register `man_pat`, `man_speed` and 0 respectively.
  - The FSM, beat counter and `step_idx` freeze and ticks are ignored. `start` and `stop` are still honoured.
  - On release, the outputs of the current state resume on the next edge.
- **`SEQ_MANUAL_OVERRIDE_EN` not defined:** these ports do not exist and the outputs come only from the FSM.

## Test plan
- **Reset:** hold `rst_n=0` → `pat_sel=111`, `gen_ena=0`, `busy=0`. Release → `gen_ena=1` after one edge.
- **Basic playback:** write entry 0 = 0x32 (pat 3, speed 0, dur 2) and entry 1 = 0x91 (speed 1, pat 1, dur 1). Apply `cfg_len=1`, `loop=0`, then `start` → `pat_sel=3` for 2 ticks, then `pat_sel=1`, `speed_sel=1` for 1 tick, then `done` pulses once and `pat_sel=111`.
- **Duration 0:** entry 0 = 0x50 with `cfg_len=0` and `loop=1` → `pat_sel=5` for 16 ticks, then step 0 reloads with no `done` pulse.
- **Pause:** assert `pause_req` mid-step for 10 ticks → `pause=1` and `step_idx` unchanged. Release → the remaining beats complete normally.
- **Simultaneous events:** `start` and `stop` on the same cycle → IDLE. `start` during PLAY → `step_idx=0` on the next edge.
- **Reset mid-playback:** assert `rst_n=0` between clock edges while `busy=1` → outputs change immediately. After release, the playlist reads as zeros (`start` → `pat_sel=0`, dur 16).

Source files
------------

// File: rtl/led_show_sequencer.sv
// led_show_sequencer: playlist-driven show controller for led_pattern_generator.
// Optional SEQ_MANUAL_OVERRIDE_EN adds man_sel/man_pat/man_speed direct output override.
module led_show_sequencer #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       cfg_we,
   input  logic [2:0] cfg_addr,
   input  logic [7:0] cfg_data,
   input  logic [2:0] cfg_len,
   input  logic       loop,
   input  logic       start,
   input  logic       stop,
   input  logic       pause_req,
`ifdef SEQ_MANUAL_OVERRIDE_EN
   input  logic       man_sel,
   input  logic [2:0] man_pat,
   input  logic       man_speed,
`endif
   output logic [2:0] pat_sel,
   output logic       speed_sel,
   output logic       pause,
   output logic       gen_ena,
   output logic [2:0] step_idx,
   output logic       busy,
   output logic       done
);
   typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;
   state_t     state_q, state_d;
   logic [7:0] mem_q [DEPTH];
   logic [7:0] mem_d [DEPTH];
   logic [7:0] cur_q, cur_d;
   logic [2:0] len_q, len_d, idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic       fin_q, fin_d;
   logic [2:0] pat_q, pat_d, step_q, step_d;
   logic       spd_q, spd_d, pause_q, pause_d, ena_q, busy_q, busy_d, done_q, done_d;
   logic       frz;
`ifdef SEQ_MANUAL_OVERRIDE_EN
   assign frz = man_sel;
`else
   assign frz = 1'b0;
`endif
   // cur_q is a private copy of the active entry so playlist writes never disturb the running step
   always_comb begin
      mem_d = mem_q;
      if (cfg_we) mem_d[cfg_addr] = cfg_data;
      state_d = state_q;
      cur_d = cur_q;
      len_d = len_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      fin_d = 1'b0;
      if (stop) begin
         state_d = IDLE;
         idx_d = '0;
      end else if (start) begin
         state_d = PLAY;
         len_d = cfg_len;
         idx_d = '0;
         cnt_d = '0;
         cur_d = mem_q[0];
      end else if (!frz) begin
         if (state_q == HOLD) begin
            state_d = pause_req ? HOLD : PLAY;
         end else if (state_q == PLAY) begin
            if (pause_req) begin
               state_d = HOLD;
            end else if (tick && cnt_q == cur_q[3:0] - 4'd1) begin
               cnt_d = '0;
               if (idx_q < len_q) begin
                  idx_d = idx_q + 3'd1;
                  cur_d = mem_q[idx_q + 3'd1];
               end else if (loop) begin
                  idx_d = '0;
                  cur_d = mem_q[0];
               end else begin
                  state_d = IDLE;
                  idx_d = '0;
                  fin_d = 1'b1;
               end
            end else if (tick) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
      end
      pat_d = (state_q == IDLE) ? 3'b111 : cur_q[6:4];
      spd_d = (state_q == IDLE) ? 1'b0 : cur_q[7];
      pause_d = (state_q == HOLD);
      busy_d = (state_q != IDLE);
      step_d = idx_q;
      done_d = fin_q;
`ifdef SEQ_MANUAL_OVERRIDE_EN
      if (man_sel) begin
         pat_d = man_pat;
         spd_d = man_speed;
         pause_d = 1'b0;
      end
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         state_q <= IDLE;
         cur_q <= '0;
         len_q <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         fin_q <= 1'b0;
         pat_q <= 3'b111;
         spd_q <= 1'b0;
         pause_q <= 1'b0;
         ena_q <= 1'b0;
         busy_q <= 1'b0;
         step_q <= '0;
         done_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         state_q <= state_d;
         cur_q <= cur_d;
         len_q <= len_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         fin_q <= fin_d;
         pat_q <= pat_d;
         spd_q <= spd_d;
         pause_q <= pause_d;
         ena_q <= 1'b1;
         busy_q <= busy_d;
         step_q <= step_d;
         done_q <= done_d;
      end
   end
   assign pat_sel = pat_q;
   assign speed_sel = spd_q;
   assign pause = pause_q;
   assign gen_ena = ena_q;
   assign step_idx = step_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule
